// File: rtl/regfile_pkg.sv
// Constants shared between the RegisterFile and its write-back buffer.
package regfile_pkg;
    localparam int RF_DATAWIDTH = 32;
    localparam int RF_ADDRWIDTH = 5;
    localparam int RF_NUMREGS   = 32;
    localparam int WB_DEPTH     = 4;
endpackage

// File: rtl/wb_bypass_match.sv
// Youngest-match search over the write-back entries, scanning from the head (oldest)
// to the tail so that the last match found is the most recently queued write.
module wb_bypass_match
    import regfile_pkg::*;
#(
    parameter int DATAWIDTH = RF_DATAWIDTH,
    parameter int ADDRWIDTH = RF_ADDRWIDTH,
    parameter int DEPTH     = WB_DEPTH,
    localparam int PTRWIDTH = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]                i_valid,
    input  logic [DEPTH-1:0][ADDRWIDTH-1:0] i_addrs,
    input  logic [DEPTH-1:0][DATAWIDTH-1:0] i_datas,
    input  logic [PTRWIDTH-1:0]             i_rdPtr,
    input  logic [ADDRWIDTH-1:0]            i_readAddr,
    output logic                            o_hit,
    output logic [DATAWIDTH-1:0]            o_data
);

    logic [PTRWIDTH-1:0] w_idx;

    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = i_rdPtr + PTRWIDTH'(k);
            if (i_valid[w_idx] && (i_addrs[w_idx] == i_readAddr)) begin
                o_hit  = 1'b1;
                o_data = i_datas[w_idx];
            end
        end
    end

endmodule

// File: rtl/regfile_wb_buffer.sv
// Write-back FIFO in front of the RegisterFile, with youngest-match read bypass.
// Optional WB_ZERO_REG_EN: writes to register 0 are accepted but discarded.
module regfile_wb_buffer
    import regfile_pkg::*;
#(
    parameter int DATAWIDTH = RF_DATAWIDTH,
    parameter int ADDRWIDTH = RF_ADDRWIDTH,
    parameter int DEPTH     = WB_DEPTH,
    localparam int PTRWIDTH = $clog2(DEPTH),
    localparam int CNTWIDTH = $clog2(DEPTH) + 1
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ADDRWIDTH-1:0] in_addr,
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic                 Stall,
    output logic                 WriteEn,
    output logic [ADDRWIDTH-1:0] WriteAddr,
    output logic [DATAWIDTH-1:0] data_o,
    input  logic [ADDRWIDTH-1:0] ReadA,
    input  logic [ADDRWIDTH-1:0] ReadB,
    output logic                 bypA_hit,
    output logic [DATAWIDTH-1:0] bypA_data,
    output logic                 bypB_hit,
    output logic [DATAWIDTH-1:0] bypB_data,
    output logic [CNTWIDTH-1:0]  count
);

    logic [PTRWIDTH-1:0]                r_wrPtr;
    logic [PTRWIDTH-1:0]                r_rdPtr;
    logic [CNTWIDTH-1:0]                r_count;
    logic [DEPTH-1:0]                   r_valid;
    logic [DEPTH-1:0][ADDRWIDTH-1:0]    r_addrs;
    logic [DEPTH-1:0][DATAWIDTH-1:0]    r_datas;

    logic                               w_empty;
    logic                               w_push;
    logic                               w_store;
    logic                               w_pop;
    logic [DEPTH-1:0]                   w_validNext;
    logic                               w_hitA;
    logic                               w_hitB;
    logic [DATAWIDTH-1:0]               w_dataA;
    logic [DATAWIDTH-1:0]               w_dataB;

    assign w_empty  = (r_count == '0);
    assign in_ready = (r_count != CNTWIDTH'(DEPTH));
    assign w_push   = in_valid & in_ready;
    assign w_pop    = ~w_empty & ~Stall;

`ifdef WB_ZERO_REG_EN
    assign w_store  = w_push & (in_addr != '0);
`else
    assign w_store  = w_push;
`endif

    assign WriteEn   = w_pop;
    assign WriteAddr = w_empty ? '0 : r_addrs[r_rdPtr];
    assign data_o    = w_empty ? '0 : r_datas[r_rdPtr];
    assign count     = r_count;

    // Storing and popping never target the same slot: a store needs a free slot, a pop needs an occupied one.
    always_comb begin
        w_validNext = r_valid;
        if (w_pop) begin
            w_validNext[r_rdPtr] = 1'b0;
        end
        if (w_store) begin
            w_validNext[r_wrPtr] = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            r_valid <= w_validNext;
            if (w_store) begin
                r_wrPtr <= r_wrPtr + PTRWIDTH'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTRWIDTH'(1);
            end
            case ({w_store, w_pop})
                2'b10:   r_count <= r_count + CNTWIDTH'(1);
                2'b01:   r_count <= r_count - CNTWIDTH'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry payload is qualified by r_valid, so it needs no reset.
    always_ff @(posedge Clk) begin
        if (w_store) begin
            r_addrs[r_wrPtr] <= in_addr;
            r_datas[r_wrPtr] <= in_data;
        end
    end

    wb_bypass_match #(
        .DATAWIDTH(DATAWIDTH),
        .ADDRWIDTH(ADDRWIDTH),
        .DEPTH    (DEPTH)
    ) u_bypassA (
        .i_valid   (r_valid),
        .i_addrs   (r_addrs),
        .i_datas   (r_datas),
        .i_rdPtr   (r_rdPtr),
        .i_readAddr(ReadA),
        .o_hit     (w_hitA),
        .o_data    (w_dataA)
    );

    wb_bypass_match #(
        .DATAWIDTH(DATAWIDTH),
        .ADDRWIDTH(ADDRWIDTH),
        .DEPTH    (DEPTH)
    ) u_bypassB (
        .i_valid   (r_valid),
        .i_addrs   (r_addrs),
        .i_datas   (r_datas),
        .i_rdPtr   (r_rdPtr),
        .i_readAddr(ReadB),
        .o_hit     (w_hitB),
        .o_data    (w_dataB)
    );

`ifdef WB_ZERO_REG_EN
    assign bypA_hit  = w_hitA & (ReadA != '0);
    assign bypA_data = bypA_hit ? w_dataA : '0;
    assign bypB_hit  = w_hitB & (ReadB != '0);
    assign bypB_data = bypB_hit ? w_dataB : '0;
`else
    assign bypA_hit  = w_hitA;
    assign bypA_data = w_dataA;
    assign bypB_hit  = w_hitB;
    assign bypB_data = w_dataB;
`endif

endmodule
